pc_stack_unit: RTL
==================

// Module: pc_stack_unit
// PURPOSE
//   Parametrised program counter with relative branch and hardware return-address stack.
//   Successor to the fixed 16-bit load/inc/reset PC.
//   Adds WIDTH/DEPTH generics, signed branch offset, call/return, stall and stack status.
//   Sits between the instruction-fetch address bus and the control unit; out drives instruction memory.
// PARAMETERS
//   WIDTH         16   address width in bits (>=4)
//   DEPTH         8    return-stack entries (>=2, power of 2)
//   RESET_VECTOR  0    value loaded into out on reset
// PORTS
//   clk        in   1                rising-edge clock
//   reset      in   1                asynchronous, active-low reset
//   stall      in   1                1 = freeze PC and stack this cycle
//   load       in   1                absolute jump: out <= in
//   in         in   WIDTH            jump/call target
//   inc        in   1                sequential step: out <= out+1
//   branch     in   1                relative jump: out <= out+offset
//   offset     in   WIDTH            two's-complement branch displacement
//   call       in   1                push out+1, out <= in
//   ret        in   1                pop, out <= popped address
//   err_clr    in   1                clears sticky overflow/underflow
//   out        out  WIDTH            current PC (registered)
//   depth      out  $clog2(DEPTH)+1  occupied stack entries
//   stk_full   out  1                depth == DEPTH
//   stk_empty  out  1                depth == 0
//   overflow   out  1                sticky: call attempted while full
//   underflow  out  1                sticky: ret attempted while empty
// BEHAVIOUR
//   - Reset (reset=0, async): out=RESET_VECTOR, depth=0, stk_empty=1, stk_full=0, overflow=underflow=0.
//   - Stack contents are not cleared by reset.
//   - All updates on clk rising edge; out is valid the cycle after the command (1-cycle latency).
//   - stall=1: out, stack, depth hold; commands ignored; err_clr still honoured.
//   - Command priority (one acts per cycle): ret > call > load > branch > inc > hold.
//   - Arithmetic is modulo 2^WIDTH. inc at all-ones wraps to 0.
//   - Branch target is out + sign-extended offset, with wrap.
//   - call, not full: mem[depth] <= out+1 (wrapped), depth++, out <= in.
//   - ret, not empty: out <= mem[depth-1], depth--.
//   - call when full (no WRAP_EN): out <= in; push discarded; depth holds; overflow <= 1.
//   - ret when empty: out holds; depth holds; underflow <= 1.
//   - err_clr=1: overflow/underflow <= 0. A same-cycle fault sets the flag (set wins over clear).
//   - Flags remain set until err_clr or reset.
//   - Reset asserted mid-operation aborts the in-flight command. First edge after deassert is a normal cycle.
//   - stk_full, stk_empty, depth are combinational from the registered depth.
// CONFIGURATION
//   PC_STACK_WRAP_EN defined: return stack is circular.
//     - call when full overwrites the oldest entry; depth stays DEPTH; overflow never sets.
//     - ret then returns the newest DEPTH entries.
//   PC_STACK_WRAP_EN undefined: saturating behaviour as above; overflow flag active.
//   underflow behaviour is identical in both builds.
// TESTING
//   1. reset=0 mid-count -> out=0, depth=0, stk_empty=1 immediately (before the next clk edge).
//   2. WIDTH=16, out=16'hFFFE, inc x3 -> out 16'hFFFF, 16'h0000, 16'h0001.
//   3. out=16'h0100, branch offset=16'hFFF0 -> out=16'h00F0.
//      - stall=1 with inc -> out unchanged.
//   4. out=16'h0010, call in=16'h0200 -> out=16'h0200, depth=1.
//      - ret -> out=16'h0011, depth=0, stk_empty=1.
//   5. DEPTH=8: 9 calls -> 9th: out=in, depth=8, overflow=1 (WRAP_EN: overflow=0).
//      - 8 rets return the newest 8 return addresses.
//   6. ret on empty -> out holds, underflow=1.
//      - err_clr with simultaneous ret-on-empty -> underflow stays 1.
//      - err_clr alone -> underflow=0.
//      - ret+call+load same cycle -> only ret acts.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with signed relative branch and a hardware return-address stack.
// Build option: define PC_STACK_WRAP_EN to make the return stack circular (overwrite oldest on full).
module pc_stack_unit #(
  parameter int          WIDTH        = 16,
  parameter int          DEPTH        = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       load,
  input  logic [WIDTH-1:0]           in,
  input  logic                       inc,
  input  logic                       branch,
  input  logic [WIDTH-1:0]           offset,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // ptr is the next write slot; in circular mode it keeps advancing past the oldest entry
  logic [AW-1:0]    ptr, ptr_nxt, ptr_dec;
  logic [DW-1:0]    depth_q, depth_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             push, ovf_set, unf_set;

  assign depth     = depth_q;
  assign stk_full  = (depth_q == DW'(DEPTH));
  assign stk_empty = (depth_q == '0);
  assign ptr_dec   = ptr - AW'(1);

  always_comb begin
    pc_nxt    = out;
    ptr_nxt   = ptr;
    depth_nxt = depth_q;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (stk_empty) begin
          unf_set = 1'b1;
        end else begin
          pc_nxt    = mem[ptr_dec];
          ptr_nxt   = ptr_dec;
          depth_nxt = depth_q - DW'(1);
        end
      end else if (call) begin
        pc_nxt = in;
        if (!stk_full) begin
          push      = 1'b1;
          ptr_nxt   = ptr + AW'(1);
          depth_nxt = depth_q + DW'(1);
        end else begin
`ifdef PC_STACK_WRAP_EN
          push    = 1'b1;
          ptr_nxt = ptr + AW'(1);
`else
          ovf_set = 1'b1;
`endif
        end
      end else if (load) begin
        pc_nxt = in;
      end else if (branch) begin
        pc_nxt = out + offset;
      end else if (inc) begin
        pc_nxt = out + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= WIDTH'(RESET_VECTOR);
      ptr       <= '0;
      depth_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= pc_nxt;
      ptr       <= ptr_nxt;
      depth_q   <= depth_nxt;
      // a fault in the same cycle as err_clr wins
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

  // Stack contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= out + WIDTH'(1);
  end

endmodule
